// File: rtl/alarm_set_ctrl_if.sv
// Alarm load interface: the setter drives the BCD time plus a one-cycle load strobe,
// and the alarm register consumes it.
interface alarm_set_ctrl_if;
  logic [7:0] D_H;
  logic [7:0] D_M;
  logic [7:0] D_S;
  logic       PE;

  modport master (output D_H, D_M, D_S, PE);
  modport slave  (input  D_H, D_M, D_S, PE);
endinterface

// File: rtl/alarm_set_ctrl.sv
// Alarm setter: debounces MODE/UP/DOWN keys and walks IDLE -> hour -> minute -> commit,
// editing a BCD working copy and pulsing PE when the new alarm time is loaded.
module alarm_set_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT_S  = 10
) (
  input  logic             CP,
  input  logic             nCR,
  input  logic             TICK,
  input  logic             KEY_MODE,
  input  logic             KEY_UP,
  input  logic             KEY_DOWN,
  alarm_set_ctrl_if.master ld,
  output logic [1:0]       SEL,
  output logic             BLINK
);

  localparam int NKEYS = 3;
  localparam int DW    = $clog2(DEB_CYCLES + 1);
  localparam int TW    = $clog2(TIMEOUT_S + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {S_IDLE, S_SET_H, S_SET_M, S_COMMIT} state_t;

  logic [NKEYS-1:0]         w_raw;
  logic [NKEYS-1:0]         r_s1, r_s2, r_deb, r_deb_d;
  logic [NKEYS-1:0][DW-1:0] r_cnt;
  logic [NKEYS-1:0]         w_ev;
  logic                     w_mode, w_up, w_dn, w_any, w_tmo;

  state_t        r_state;
  logic [1:0]    r_sel;
  logic          r_pe, r_blink;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_com_h, r_com_m, r_work_h, r_work_m;

  assign w_raw = {KEY_DOWN, KEY_UP, KEY_MODE};

  // Level only flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int k = 0; k < NKEYS; k++) begin
        if (r_s2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DEB_LAST) begin
          r_deb[k] <= r_s2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_ev   = r_deb & ~r_deb_d;
  assign w_mode = w_ev[0];
  assign w_up   = w_ev[1] & ~w_ev[2] & ~w_ev[0];
  assign w_dn   = w_ev[2] & ~w_ev[1] & ~w_ev[0];
  assign w_any  = |w_ev;
  assign w_tmo  = TICK && !w_any && (r_tmo == TMO_LAST);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)           return 8'h00;
    if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)         return max;
    if (v[3:0] == 4'd0)     return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // work mirrors committed whenever idle, so the display is always r_work.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_state  <= S_IDLE;
      r_sel    <= 2'b00;
      r_pe     <= 1'b0;
      r_blink  <= 1'b0;
      r_tmo    <= '0;
      r_com_h  <= 8'h00;
      r_com_m  <= 8'h00;
      r_work_h <= 8'h00;
      r_work_m <= 8'h00;
    end else begin
      r_pe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_state  <= S_SET_H;
            r_sel    <= 2'b01;
            r_blink  <= 1'b0;
            r_tmo    <= '0;
            r_work_h <= r_com_h;
            r_work_m <= r_com_m;
          end
        end
        S_SET_H, S_SET_M: begin
          if (w_tmo) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'b00;
            r_blink  <= 1'b0;
            r_tmo    <= '0;
            r_work_h <= r_com_h;
            r_work_m <= r_com_m;
          end else begin
            if (w_any)     r_tmo <= '0;
            else if (TICK) r_tmo <= r_tmo + 1'b1;
            if (TICK) r_blink <= ~r_blink;
            if (w_mode) begin
              if (r_state == S_SET_H) begin
                r_state <= S_SET_M;
                r_sel   <= 2'b10;
              end else begin
                r_state <= S_COMMIT;
                r_pe    <= 1'b1;
                r_blink <= 1'b0;
              end
            end else if (w_up) begin
              if (r_state == S_SET_H) r_work_h <= bcd_inc(r_work_h, 8'h23);
              else                    r_work_m <= bcd_inc(r_work_m, 8'h59);
            end else if (w_dn) begin
              if (r_state == S_SET_H) r_work_h <= bcd_dec(r_work_h, 8'h23);
              else                    r_work_m <= bcd_dec(r_work_m, 8'h59);
            end
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_sel   <= 2'b00;
          r_com_h <= r_work_h;
          r_com_m <= r_work_m;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld.D_H = r_work_h;
  assign ld.D_M = r_work_m;
  assign ld.D_S = 8'h00;
  assign ld.PE  = r_pe;
  assign SEL    = r_sel;
  assign BLINK  = r_blink;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: key presses push expected {H,M,SEL} to a scoreboard
// that is popped when the debounced event has landed in the outputs.
module tb_alarm_set_ctrl;
  localparam int D  = 16;
  localparam int TO = 10;

  logic       CP = 1'b0, nCR = 1'b0, TICK = 1'b0;
  logic [2:0] keys = 3'b000;
  logic [1:0] SEL;
  logic       BLINK;

  alarm_set_ctrl_if ld();

  alarm_set_ctrl #(.DEB_CYCLES(D), .TIMEOUT_S(TO)) dut (
    .CP(CP), .nCR(nCR), .TICK(TICK),
    .KEY_MODE(keys[0]), .KEY_UP(keys[1]), .KEY_DOWN(keys[2]),
    .ld(ld), .SEL(SEL), .BLINK(BLINK)
  );

  always #5 CP = ~CP;

  typedef struct {
    string      tag;
    logic [7:0] h;
    logic [7:0] m;
    logic [1:0] sel;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0, pe_cnt = 0;
  logic [7:0] pe_h = 8'h00, pe_m = 8'h00, pe_s = 8'hff;
  logic [7:0] cur_h = 8'h00, cur_m = 8'h00;
  logic [1:0] cur_sel = 2'b00;

  always @(negedge CP) begin
    if (ld.PE === 1'b1) begin
      pe_cnt++;
      pe_h = ld.D_H;
      pe_m = ld.D_M;
      pe_s = ld.D_S;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raw press at a clock edge; output must still be old at D+2 and updated at D+3.
  task automatic press(input logic [2:0] mask, input logic [7:0] h, input logic [7:0] m,
                       input logic [1:0] s, input string tag);
    exp_t e;
    sb.push_back('{tag: tag, h: h, m: m, sel: s});
    @(posedge CP); #1 keys = mask;
    repeat (D + 2) @(posedge CP);
    @(negedge CP);
    chk({tag, "_early"}, {8'h0, ld.D_H, ld.D_M, 6'b0, SEL}, {8'h0, cur_h, cur_m, 6'b0, cur_sel});
    @(posedge CP); @(negedge CP);
    e = sb.pop_front();
    chk(e.tag, {8'h0, ld.D_H, ld.D_M, 6'b0, SEL}, {8'h0, e.h, e.m, 6'b0, e.sel});
    cur_h = e.h; cur_m = e.m; cur_sel = e.sel;
    #1 keys = 3'b000;
    repeat (D + 6) @(posedge CP);
  endtask

  task automatic tick();
    @(posedge CP); #1 TICK = 1'b1;
    @(posedge CP); #1 TICK = 1'b0;
  endtask

  initial begin
    exp_t       e;
    logic [7:0] pat;

    // Reset held while all keys are pressed
    repeat (3) @(posedge CP);
    #1 keys = 3'b111;
    repeat (D + 4) @(posedge CP);
    #1 keys = 3'b000;
    @(negedge CP);
    chk("rst_dh", ld.D_H, 8'h00);
    chk("rst_dm", ld.D_M, 8'h00);
    chk("rst_ds", ld.D_S, 8'h00);
    chk("rst_pe", ld.PE, 1'b0);
    chk("rst_sel", SEL, 2'b00);
    chk("rst_blink", BLINK, 1'b0);
    #1 nCR = 1'b1;
    repeat (D + 6) @(posedge CP);
    @(negedge CP);
    chk("post_rst", {ld.D_H, ld.D_M, ld.D_S, 6'b0, SEL, ld.PE, BLINK}, 32'h0);

    // Hour wrap, blink phase, then full edit and commit
    press(3'b001, 8'h00, 8'h00, 2'b01, "enter_h");
    chk("blink_entry", BLINK, 1'b0);
    tick(); @(negedge CP); chk("blink_t1", BLINK, 1'b1);
    tick(); @(negedge CP); chk("blink_t2", BLINK, 1'b0);
    press(3'b100, 8'h23, 8'h00, 2'b01, "h_down_wrap");
    press(3'b010, 8'h00, 8'h00, 2'b01, "h_up_wrap");
    for (int i = 1; i <= 7; i++) press(3'b010, bcd(i), 8'h00, 2'b01, "h_up");
    press(3'b001, 8'h07, 8'h00, 2'b10, "enter_m");
    for (int i = 1; i <= 30; i++) press(3'b010, 8'h07, bcd(i), 2'b10, "m_up");
    press(3'b001, 8'h07, 8'h30, 2'b10, "commit1");
    cur_sel = 2'b00;
    chk("pe_cnt1", pe_cnt, 1);
    chk("pe_data1", {8'h0, pe_h, pe_m, pe_s}, {8'h0, 8'h07, 8'h30, 8'h00});
    @(negedge CP);
    chk("idle_after1", {8'h0, ld.D_H, ld.D_M, 6'b0, SEL}, {8'h0, 8'h07, 8'h30, 8'h00});

    // Minute BCD carry/borrow and wrap
    press(3'b001, 8'h07, 8'h30, 2'b01, "enter_h2");
    press(3'b001, 8'h07, 8'h30, 2'b10, "enter_m2");
    for (int i = 29; i >= 9; i--) press(3'b100, 8'h07, bcd(i), 2'b10, "m_down");
    press(3'b010, 8'h07, 8'h10, 2'b10, "m_09_up");
    press(3'b100, 8'h07, 8'h09, 2'b10, "m_10_down");
    for (int i = 8; i >= 0; i--) press(3'b100, 8'h07, bcd(i), 2'b10, "m_down2");
    press(3'b100, 8'h07, 8'h59, 2'b10, "m_down_wrap");
    press(3'b010, 8'h07, 8'h00, 2'b10, "m_up_wrap");
    press(3'b001, 8'h07, 8'h00, 2'b10, "commit2");
    cur_sel = 2'b00;
    chk("pe_cnt2", pe_cnt, 2);
    chk("pe_data2", {8'h0, pe_h, pe_m, pe_s}, {8'h0, 8'h07, 8'h00, 8'h00});

    // Debounce: short glitch ignored, bouncing press counts once
    press(3'b001, 8'h07, 8'h00, 2'b01, "enter_h3");
    @(posedge CP); #1 keys = 3'b010;
    repeat (5) @(posedge CP);
    #1 keys = 3'b000;
    repeat (D + 6) @(posedge CP);
    @(negedge CP);
    chk("glitch", ld.D_H, 8'h07);
    sb.push_back('{tag: "bounce", h: 8'h08, m: 8'h00, sel: 2'b01});
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      @(posedge CP); #1 keys[1] = pat[i];
    end
    @(posedge CP); #1 keys[1] = 1'b1;
    repeat (D + 4) @(posedge CP);
    @(negedge CP);
    e = sb.pop_front();
    chk(e.tag, {8'h0, ld.D_H, ld.D_M, 6'b0, SEL}, {8'h0, e.h, e.m, 6'b0, e.sel});
    cur_h = e.h;
    pat = 8'b0000_0010;
    for (int i = 0; i < 4; i++) begin
      @(posedge CP); #1 keys[1] = pat[i];
    end
    repeat (D + 6) @(posedge CP);
    @(negedge CP);
    chk("bounce_release", ld.D_H, 8'h08);

    // Timeout discards the edit
    press(3'b010, 8'h09, 8'h00, 2'b01, "h_09");
    press(3'b010, 8'h10, 8'h00, 2'b01, "h_10");
    press(3'b010, 8'h11, 8'h00, 2'b01, "h_11");
    for (int i = 0; i < TO - 1; i++) tick();
    @(negedge CP);
    chk("tmo_pre_sel", SEL, 2'b01);
    chk("tmo_pre_blink", BLINK, 1'b1);
    tick();
    @(negedge CP);
    chk("tmo_sel", SEL, 2'b00);
    chk("tmo_revert", {16'h0, ld.D_H, ld.D_M}, {16'h0, 8'h07, 8'h00});
    chk("tmo_blink", BLINK, 1'b0);
    chk("tmo_no_pe", pe_cnt, 2);
    cur_h = 8'h07; cur_m = 8'h00; cur_sel = 2'b00;

    // Simultaneous events, then reset mid-edit
    press(3'b001, 8'h07, 8'h00, 2'b01, "enter_h4");
    press(3'b110, 8'h07, 8'h00, 2'b01, "up_dn_same");
    press(3'b011, 8'h07, 8'h00, 2'b10, "mode_up_same");
    press(3'b010, 8'h07, 8'h01, 2'b10, "m_up_01");
    @(posedge CP); #2 nCR = 1'b0;
    #1;
    chk("midrst", {ld.D_H, ld.D_M, 6'b0, SEL, ld.PE, BLINK}, 32'h0);
    repeat (3) @(posedge CP);
    #1 nCR = 1'b1;
    cur_h = 8'h00; cur_m = 8'h00; cur_sel = 2'b00;
    repeat (D + 6) @(posedge CP);
    @(negedge CP);
    chk("midrst_hold", {ld.D_H, ld.D_M, 6'b0, SEL, ld.PE, BLINK}, 32'h0);
    press(3'b001, 8'h00, 8'h00, 2'b01, "enter_after_rst");
    chk("final_pe_cnt", pe_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
